cafe_order_sched: RTL and testbench
===================================

CAFE_ORDER_SCHED -- requirements
Module: cafe_order_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 200, brewer-response timeout in clk cycles (range 1..255).
REQ-002 Parameter QDEPTH, default 4, order-queue depth (power of two, 2..8).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  order request per front-panel station, level, held until granted.
REQ-006 sel  input  8  drink code per station, 2 bits each: station i uses sel[2i+1:2i].
REQ-007 brew_done  input  1  single-cycle pulse from the brewing unit: drink finished.
REQ-008 err_clr  input  1  operator acknowledge of timeout error.
REQ-009 grant  output  4  one-hot, same-cycle acknowledge that station i's order is enqueued.
REQ-010 brew_start  output  1  single-cycle start pulse to the brewing unit.
REQ-011 brew_type  output  2  drink code of the current order, valid from brew_start until completion.
REQ-012 busy  output  1  high in ISSUE, WAIT and DONE.
REQ-013 q_count  output  4  number of queued orders, 0..QDEPTH.
REQ-014 full  output  1  q_count == QDEPTH.
REQ-015 timeout_err  output  1  high while in ERR.

Function
REQ-016 Arbitration: round-robin over req; search starts at station (last_grant+1) mod 4; at most one grant per cycle.
REQ-017 A grant is issued only if the queue is not full, or a pop occurs in the same cycle; with full and no pop, grant = 0.
REQ-018 On grant to station i, {sel[2i+1:2i]} is pushed into the queue on the same clock edge; last_grant updates to i.
REQ-019 Queue is FIFO; simultaneous push and pop leave q_count unchanged; pop of an empty queue never occurs.
REQ-020 FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
REQ-021 IDLE: if q_count != 0, move to ISSUE next cycle; otherwise stay.
REQ-022 ISSUE (exactly one cycle): brew_start = 1, head popped, brew_type loaded with head code; then WAIT.
REQ-023 WAIT: an 8-bit timer, cleared on entry, increments each cycle; brew_done -> DONE; timer == TIMEOUT_CYC-1 without brew_done -> ERR.
REQ-024 brew_done and timeout in the same cycle: brew_done wins (DONE).
REQ-025 DONE (exactly one cycle): then IDLE; brew_done outside WAIT is ignored.
REQ-026 ERR: timeout_err = 1, no brew_start; stays until err_clr, then IDLE; the failed order is discarded.
REQ-027 Arbitration and enqueueing continue in every state, including ERR.
REQ-028 Latency: order granted into an empty queue in IDLE produces brew_start 2 cycles after the grant edge.

Reset
REQ-029 On rst: state IDLE, queue emptied, q_count 0, last_grant = 3 (station 0 first), timer 0.
REQ-030 Reset values: grant 0, brew_start 0, brew_type 00, busy 0, full 0, timeout_err 0.
REQ-031 rst mid-brew aborts the order with no further brew_start; rst overrides all inputs in that cycle.

Structure
REQ-032 Package cafe_pkg holds FSM state encoding (3-bit) and drink codes: 00 espresso, 01 americano, 10 latte, 11 hot water.
REQ-033 The queue is sub-module cafe_order_fifo (2-bit data, QDEPTH entries, push/pop/count, synchronous reset); arbiter and FSM stay in the top.

Verification
REQ-034 req=0001, sel[1:0]=10, queue empty -> grant=0001 at cycle 0, brew_start with brew_type=10 at cycle 2; brew_done at cycle 5 -> busy low at cycle 7.
REQ-035 req=1111 held, no brew_done -> grants 0001,0010,0100,1000 in order; q_count reaches 4 (minus 1 popped), full blocks further grants.
REQ-036 Queue full and ISSUE pops in same cycle while req=0010 -> grant=0010, q_count stays 4.
REQ-037 TIMEOUT_CYC=10, no brew_done -> timeout_err rises 10 cycles after ISSUE; err_clr -> IDLE, next queued order issued.
REQ-038 brew_done coincident with last timer cycle -> DONE, timeout_err stays 0.
REQ-039 rst asserted in WAIT with 3 queued -> next cycle all outputs at reset values, q_count 0.

Source files
------------

// File: rtl/cafe_pkg.sv
// rtl/cafe_pkg.sv - shared FSM state encoding and drink codes for the cafe order scheduler
package cafe_pkg;

  // Brewer control FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Drink codes carried through the order queue to the brewing unit
  localparam logic [1:0] DRINK_ESPRESSO  = 2'b00;
  localparam logic [1:0] DRINK_AMERICANO = 2'b01;
  localparam logic [1:0] DRINK_LATTE     = 2'b10;
  localparam logic [1:0] DRINK_HOT_WATER = 2'b11;

  localparam int NUM_STATIONS = 4;

endpackage

// File: rtl/cafe_order_fifo.sv
// rtl/cafe_order_fifo.sv - order queue holding 2-bit drink codes, first in first out
module cafe_order_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [1:0] push_data_i,
  input  logic       pop_i,
  output logic [1:0] pop_data_o,
  output logic [3:0] count_o
);

  // QDEPTH is a power of two, so the pointers wrap naturally
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [1:0]    mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [3:0]    count_q;

  // Pointer/count update with synchronous reset; storage is written on push
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/cafe_order_sched.sv
// rtl/cafe_order_sched.sv - round-robin order intake, queueing and brewer sequencing with timeout
module cafe_order_sched
  import cafe_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200,
  parameter int QDEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] sel,
  input  logic       brew_done,
  input  logic       err_clr,
  output logic [3:0] grant,
  output logic       brew_start,
  output logic [1:0] brew_type,
  output logic       busy,
  output logic [3:0] q_count,
  output logic       full,
  output logic       timeout_err
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] Q_FULL     = 4'(QDEPTH);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] brew_type_q, brew_type_d;
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] cand;
  logic       push, pop, can_push;
  logic [1:0] push_code, head_code;

  // The head is consumed in the single ISSUE cycle; a pop frees a slot for a same-cycle push
  assign pop      = (state_q == ST_ISSUE);
  assign full     = (q_count == Q_FULL);
  assign can_push = !full || pop;

  // Round-robin search starting one past the last granted station; at most one grant
  always_comb begin
    grant        = '0;
    push         = 1'b0;
    push_code    = DRINK_ESPRESSO;
    last_grant_d = last_grant_q;
    cand         = 2'd0;
    for (int k = 1; k <= NUM_STATIONS; k++) begin
      cand = last_grant_q + 2'(k);
      if (!push && !rst && can_push && req[cand]) begin
        push         = 1'b1;
        grant[cand]  = 1'b1;
        push_code    = sel[{cand, 1'b0} +: 2];
        last_grant_d = cand;
      end
    end
  end

  cafe_order_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_code),
    .pop_i       (pop),
    .pop_data_o  (head_code),
    .count_o     (q_count)
  );

  // Brewer FSM next state; brew_done is only honoured in WAIT and beats a coincident timeout
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    brew_type_d = brew_type_q;
    case (state_q)
      ST_IDLE: begin
        if (q_count != 4'd0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        brew_type_d = head_code;
        timer_d     = 8'd0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (brew_done) begin
          state_d = ST_DONE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clr) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timer, current drink and arbitration pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      brew_type_q  <= DRINK_ESPRESSO;
      last_grant_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      brew_type_q  <= brew_type_d;
      last_grant_q <= last_grant_d;
    end
  end

  // During ISSUE the register is not loaded yet, so show the queue head directly
  assign brew_start  = (state_q == ST_ISSUE);
  assign brew_type   = (state_q == ST_ISSUE) ? head_code : brew_type_q;
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_DONE);
  assign timeout_err = (state_q == ST_ERR);

endmodule

// File: tb/tb_cafe_order_sched.sv
// tb/tb_cafe_order_sched.sv - directed scoreboard bench for cafe_order_sched
module tb_cafe_order_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] sel;
  logic       brew_done;
  logic       err_clr;
  logic [3:0] grant;
  logic       brew_start;
  logic [1:0] brew_type;
  logic       busy;
  logic [3:0] q_count;
  logic       full;
  logic       timeout_err;

  int n_pass   = 0;
  int n_total  = 0;
  int n_starts = 0;
  logic [1:0] sb [$];

  cafe_order_sched #(
    .TIMEOUT_CYC(10),
    .QDEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .sel         (sel),
    .brew_done   (brew_done),
    .err_clr     (err_clr),
    .grant       (grant),
    .brew_start  (brew_start),
    .brew_type   (brew_type),
    .busy        (busy),
    .q_count     (q_count),
    .full        (full),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Every brew_start must match the oldest expected drink code
  always @(negedge clk) begin
    if (!rst && brew_start === 1'b1) begin
      n_starts++;
      if (sb.size() == 0) check("unexpected_brew_start", 8'd1, 8'd0);
      else check("sb_brew_type", {6'd0, brew_type}, {6'd0, sb.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; req = 4'd0; sel = 8'd0; brew_done = 1'b0; err_clr = 1'b0;
    tick(); tick(); mid();
    check("rst_grant", {4'd0, grant}, 8'd0);
    check("rst_brew_start", {7'd0, brew_start}, 8'd0);
    check("rst_brew_type", {6'd0, brew_type}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_q_count", {4'd0, q_count}, 8'd0);
    check("rst_full", {7'd0, full}, 8'd0);
    check("rst_timeout_err", {7'd0, timeout_err}, 8'd0);

    // Single latte order from station 0
    tick(); rst = 1'b0; req = 4'b0001; sel = 8'b0000_0010; sb.push_back(2'b10); mid();
    check("t1_grant_c0", {4'd0, grant}, 8'h01);
    tick(); req = 4'd0; mid();
    check("t1_q_count_c1", {4'd0, q_count}, 8'd1);
    check("t1_no_start_c1", {7'd0, brew_start}, 8'd0);
    tick(); mid();
    check("t1_start_c2", {7'd0, brew_start}, 8'd1);
    check("t1_type_c2", {6'd0, brew_type}, 8'h02);
    check("t1_busy_c2", {7'd0, busy}, 8'd1);
    tick(); mid();
    tick(); mid();
    check("t1_type_held_c4", {6'd0, brew_type}, 8'h02);
    tick(); brew_done = 1'b1; mid();
    tick(); brew_done = 1'b0; mid();
    check("t1_busy_done_c6", {7'd0, busy}, 8'd1);
    tick(); mid();
    check("t1_busy_low_c7", {7'd0, busy}, 8'd0);

    // brew_done on the final timer cycle wins over the timeout
    tick(); req = 4'b0010; sel = 8'b0000_0100; sb.push_back(2'b01); mid();
    check("t2_grant", {4'd0, grant}, 8'h02);
    tick(); req = 4'd0; mid();
    repeat (10) begin tick(); mid(); end
    tick(); brew_done = 1'b1; mid();
    check("t2_no_err_c12", {7'd0, timeout_err}, 8'd0);
    tick(); brew_done = 1'b0; mid();
    check("t2_done_busy", {7'd0, busy}, 8'd1);
    check("t2_done_no_err", {7'd0, timeout_err}, 8'd0);
    tick(); mid();
    check("t2_idle_busy", {7'd0, busy}, 8'd0);
    check("t2_idle_no_err", {7'd0, timeout_err}, 8'd0);

    // All stations request; queue fills, then the order times out
    tick(); rst = 1'b1; mid();
    tick(); rst = 1'b0; req = 4'b1111; sel = 8'b11_10_01_00; sb.push_back(2'b00); mid();
    check("t3_grant_c0", {4'd0, grant}, 8'h01);
    tick(); sb.push_back(2'b01); mid();
    check("t3_grant_c1", {4'd0, grant}, 8'h02);
    check("t3_q_c1", {4'd0, q_count}, 8'd1);
    tick(); sb.push_back(2'b10); mid();
    check("t3_grant_c2", {4'd0, grant}, 8'h04);
    check("t3_q_c2", {4'd0, q_count}, 8'd2);
    tick(); sb.push_back(2'b11); mid();
    check("t3_grant_c3", {4'd0, grant}, 8'h08);
    check("t3_q_c3", {4'd0, q_count}, 8'd2);
    tick(); sb.push_back(2'b00); mid();
    check("t3_grant_c4", {4'd0, grant}, 8'h01);
    check("t3_q_c4", {4'd0, q_count}, 8'd3);
    tick(); mid();
    check("t3_full_grant_c5", {4'd0, grant}, 8'h00);
    check("t3_q_c5", {4'd0, q_count}, 8'd4);
    check("t3_full_c5", {7'd0, full}, 8'd1);
    tick(); req = 4'd0; mid();
    repeat (5) begin tick(); mid(); end
    tick(); mid();
    check("t3_no_err_c12", {7'd0, timeout_err}, 8'd0);
    check("t3_busy_c12", {7'd0, busy}, 8'd1);
    tick(); mid();
    check("t3_err_c13", {7'd0, timeout_err}, 8'd1);
    check("t3_err_busy_c13", {7'd0, busy}, 8'd0);
    check("t3_err_no_start", {7'd0, brew_start}, 8'd0);
    tick(); err_clr = 1'b1; mid();
    check("t3_err_held_c14", {7'd0, timeout_err}, 8'd1);
    tick(); err_clr = 1'b0; mid();
    check("t3_cleared_c15", {7'd0, timeout_err}, 8'd0);
    check("t3_q_c15", {4'd0, q_count}, 8'd4);

    // Full queue, ISSUE pop and a new grant in the same cycle
    tick(); req = 4'b0010; sel = 8'b0000_0100; sb.push_back(2'b01); mid();
    check("t4_grant_on_pop", {4'd0, grant}, 8'h02);
    check("t4_start", {7'd0, brew_start}, 8'd1);
    tick(); req = 4'd0; mid();
    check("t4_q_stays", {4'd0, q_count}, 8'd4);
    check("t4_full", {7'd0, full}, 8'd1);
    check("t4_sb_pending", sb.size(), 8'd4);

    // Reset during WAIT with orders queued
    tick(); rst = 1'b1; mid();
    tick(); rst = 1'b0; sb.delete(); mid();
    check("t5_grant", {4'd0, grant}, 8'd0);
    check("t5_brew_start", {7'd0, brew_start}, 8'd0);
    check("t5_brew_type", {6'd0, brew_type}, 8'd0);
    check("t5_busy", {7'd0, busy}, 8'd0);
    check("t5_q_count", {4'd0, q_count}, 8'd0);
    check("t5_full", {7'd0, full}, 8'd0);
    check("t5_timeout_err", {7'd0, timeout_err}, 8'd0);
    repeat (6) begin tick(); mid(); end
    check("t5_still_idle", {7'd0, busy}, 8'd0);
    check("total_brew_starts", n_starts[7:0], 8'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
